// File: rtl/led_blink_scheduler.sv
// Multi-channel LED scheduler: one shared prescaler tick drives per-channel
// OFF/SOLID/BLINK/ONESHOT state machines configured over a valid/ready port.
module led_blink_scheduler #(
    parameter int unsigned N_LEDS   = 4,
    parameter int unsigned TICK_DIV = 500,
    parameter int unsigned PERIOD_W = 8,
    localparam int unsigned CHAN_W  = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                io_en,
    input  logic                io_cfg_valid,
    output logic                io_cfg_ready,
    input  logic [CHAN_W-1:0]   io_cfg_chan,
    input  logic [1:0]          io_cfg_mode,
    input  logic [PERIOD_W-1:0] io_cfg_period,
    output logic [N_LEDS-1:0]   io_leds,
    output logic [N_LEDS-1:0]   io_done,
    output logic                io_busy
);

    localparam int unsigned PRE_W = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_SOLID   = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_ONESHOT = 2'd3
    } mode_t;

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic [N_LEDS-1:0]   led_q, led_d;
    logic [N_LEDS-1:0]   done_q, done_d;
    mode_t               mode_q   [N_LEDS];
    mode_t               mode_d   [N_LEDS];
    logic [PERIOD_W-1:0] period_q [N_LEDS];
    logic [PERIOD_W-1:0] period_d [N_LEDS];
    logic [PERIOD_W-1:0] count_q  [N_LEDS];
    logic [PERIOD_W-1:0] count_d  [N_LEDS];

    logic                tick_c;
    logic                accept_c;
    logic [PERIOD_W-1:0] wr_period_c;

    assign tick_c      = io_en && (pre_q == PRE_W'(TICK_DIV - 1));
    assign accept_c    = io_cfg_valid && ready_q;
    assign wr_period_c = (io_cfg_period == '0) ? PERIOD_W'(1) : io_cfg_period;

    assign io_cfg_ready = ready_q;
    assign io_leds      = led_q;
    assign io_done      = done_q;
    assign io_busy      = busy_q;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pre_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            led_q   <= '0;
            done_q  <= '0;
            for (int i = 0; i < N_LEDS; i++) begin
                mode_q[i]   <= MODE_OFF;
                period_q[i] <= PERIOD_W'(1);
                count_q[i]  <= '0;
            end
        end else begin
            pre_q   <= pre_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            led_q   <= led_d;
            done_q  <= done_d;
            for (int i = 0; i < N_LEDS; i++) begin
                mode_q[i]   <= mode_d[i];
                period_q[i] <= period_d[i];
                count_q[i]  <= count_d[i];
            end
        end
    end

    // Next-state: prescaler, handshake, per-channel mode machines
    always_comb begin
        pre_d   = pre_q;
        ready_d = ~accept_c;
        led_d   = led_q;
        done_d  = '0;
        busy_d  = 1'b0;

        if (io_en) begin
            pre_d = tick_c ? '0 : pre_q + PRE_W'(1);
        end

        for (int i = 0; i < N_LEDS; i++) begin
            mode_d[i]   = mode_q[i];
            period_d[i] = period_q[i];
            count_d[i]  = count_q[i];

            // A write to this channel takes priority over a coincident tick
            if (accept_c && (io_cfg_chan == CHAN_W'(i))) begin
                mode_d[i]   = mode_t'(io_cfg_mode);
                period_d[i] = wr_period_c;
                count_d[i]  = '0;
                led_d[i]    = (io_cfg_mode != 2'(MODE_OFF));
            end else if (tick_c) begin
                case (mode_q[i])
                    MODE_SOLID: led_d[i] = 1'b1;
                    MODE_BLINK: begin
                        if (count_q[i] == period_q[i] - PERIOD_W'(1)) begin
                            count_d[i] = '0;
                            led_d[i]   = ~led_q[i];
                        end else begin
                            count_d[i] = count_q[i] + PERIOD_W'(1);
                        end
                    end
                    MODE_ONESHOT: begin
                        if (count_q[i] == period_q[i] - PERIOD_W'(1)) begin
                            mode_d[i]  = MODE_OFF;
                            count_d[i] = '0;
                            led_d[i]   = 1'b0;
                            done_d[i]  = 1'b1;
                        end else begin
                            count_d[i] = count_q[i] + PERIOD_W'(1);
                        end
                    end
                    default: led_d[i] = 1'b0;
                endcase
            end

            busy_d = busy_d | (mode_d[i] != MODE_OFF);
        end
    end

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Randomised and directed bench for led_blink_scheduler against a tick-countdown
// reference model.
module tb_led_blink_scheduler;

    localparam int unsigned N  = 3;
    localparam int unsigned TD = 4;
    localparam int unsigned PW = 8;
    localparam int unsigned CW = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          io_en = 1'b0;
    logic          io_cfg_valid = 1'b0;
    logic          io_cfg_ready;
    logic [CW-1:0] io_cfg_chan = '0;
    logic [1:0]    io_cfg_mode = '0;
    logic [PW-1:0] io_cfg_period = '0;
    logic [N-1:0]  io_leds;
    logic [N-1:0]  io_done;
    logic          io_busy;

    int checks = 0;
    int errors = 0;

    led_blink_scheduler #(.N_LEDS(N), .TICK_DIV(TD), .PERIOD_W(PW)) dut (
        .clock         (clock),
        .reset         (reset),
        .io_en         (io_en),
        .io_cfg_valid  (io_cfg_valid),
        .io_cfg_ready  (io_cfg_ready),
        .io_cfg_chan   (io_cfg_chan),
        .io_cfg_mode   (io_cfg_mode),
        .io_cfg_period (io_cfg_period),
        .io_leds       (io_leds),
        .io_done       (io_done),
        .io_busy       (io_busy)
    );

    always #5 clock = ~clock;

    // Reference model: each channel counts remaining ticks in its current phase
    int           m_pre;
    bit           m_ready, m_acc, m_busy;
    int           m_mode [N];
    int           m_per  [N];
    int           m_left [N];
    logic [N-1:0] m_leds, m_done;

    always @(posedge clock or negedge reset) begin : model
        bit tick;
        if (!reset) begin
            m_pre = 0; m_ready = 0; m_acc = 0; m_busy = 0;
            m_leds = '0; m_done = '0;
            for (int c = 0; c < N; c++) begin
                m_mode[c] = 0; m_per[c] = 1; m_left[c] = 1;
            end
        end else begin
            tick  = io_en && (m_pre == TD - 1);
            m_acc = io_cfg_valid && m_ready;
            m_done = '0;
            for (int c = 0; c < N; c++) begin
                if (m_acc && int'(io_cfg_chan) == c) begin
                    m_mode[c] = int'(io_cfg_mode);
                    m_per[c]  = (io_cfg_period == 0) ? 1 : int'(io_cfg_period);
                    m_left[c] = m_per[c];
                    m_leds[c] = (m_mode[c] != 0);
                end else if (tick) begin
                    if (m_mode[c] == 2 || m_mode[c] == 3) begin
                        m_left[c]--;
                        if (m_left[c] == 0) begin
                            if (m_mode[c] == 2) begin
                                m_leds[c] = ~m_leds[c];
                                m_left[c] = m_per[c];
                            end else begin
                                m_mode[c] = 0;
                                m_leds[c] = 1'b0;
                                m_done[c] = 1'b1;
                            end
                        end
                    end
                end
            end
            if (io_en) m_pre = tick ? 0 : m_pre + 1;
            m_ready = !m_acc;
            m_busy = 0;
            for (int c = 0; c < N; c++) if (m_mode[c] != 0) m_busy = 1;
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic cfg_write(input logic [CW-1:0] ch, input logic [1:0] md,
                             input logic [PW-1:0] per);
        int n = 0;
        io_cfg_valid = 1'b1; io_cfg_chan = ch; io_cfg_mode = md; io_cfg_period = per;
        do begin
            @(posedge clock); #1; n++;
        end while (!m_acc && n < 8);
        @(negedge clock);
        io_cfg_valid = 1'b0;
    endtask

    task automatic align(input int pre);
        for (int n = 0; n < 20 && !(m_pre == pre && m_ready); n++) @(negedge clock);
    endtask

    task automatic test_reset;
        reset = 1'b0; io_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++;
            if ({io_cfg_ready, io_busy, io_done, io_leds} !== 8'b0) begin
                errors++;
                $display("FAIL reset_hold got %b exp %b",
                         {io_cfg_ready, io_busy, io_done, io_leds}, 8'b0);
            end
        end
        reset = 1'b1;
        #1;
        checks++;
        if (io_cfg_ready !== 1'b0) begin
            errors++; $display("FAIL ready_before_edge got %b exp 0", io_cfg_ready);
        end
        @(posedge clock); #1;
        checks++;
        if ({io_cfg_ready, io_busy, io_done, io_leds} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL ready_after_edge got %b exp %b",
                     {io_cfg_ready, io_busy, io_done, io_leds}, 8'b1000_0000);
        end
        @(negedge clock);
    endtask

    task automatic test_blink;
        int last = 0, toggles = 0;
        logic prev = 1'b1;
        align(TD - 1);
        cfg_write(2'd1, 2'd2, 8'd2);
        for (int k = 0; k < 40; k++) begin
            checks++;
            if ({io_cfg_ready, io_busy, io_done, io_leds} !== {m_ready, m_busy, m_done, m_leds}) begin
                errors++;
                $display("FAIL blink cyc %0d got %b exp %b", k,
                         {io_cfg_ready, io_busy, io_done, io_leds}, {m_ready, m_busy, m_done, m_leds});
            end
            if (io_leds[1] !== prev) begin
                toggles++;
                checks++;
                if (k - last != 8) begin
                    errors++; $display("FAIL blink_interval got %0d exp 8", k - last);
                end
                last = k; prev = io_leds[1];
            end
            @(negedge clock);
        end
        checks++;
        if (toggles < 4) begin
            errors++; $display("FAIL blink_toggles got %0d exp >=4", toggles);
        end
    endtask

    task automatic test_oneshot;
        int hi = 0, dones = 0;
        cfg_write(2'd1, 2'd0, 8'd0);
        repeat ($urandom_range(0, 3)) @(negedge clock);
        cfg_write(2'd0, 2'd3, 8'd3);
        for (int k = 0; k < 20; k++) begin
            checks++;
            if ({io_cfg_ready, io_busy, io_done, io_leds} !== {m_ready, m_busy, m_done, m_leds}) begin
                errors++;
                $display("FAIL oneshot cyc %0d got %b exp %b", k,
                         {io_cfg_ready, io_busy, io_done, io_leds}, {m_ready, m_busy, m_done, m_leds});
            end
            if (io_leds[0] === 1'b1) hi++;
            if (io_done[0] === 1'b1) dones++;
            @(negedge clock);
        end
        checks++;
        if (hi < 9 || hi > 12) begin
            errors++; $display("FAIL oneshot_len got %0d exp 9..12", hi);
        end
        checks++;
        if (dones != 1) begin
            errors++; $display("FAIL oneshot_done got %0d exp 1", dones);
        end
        checks++;
        if (io_busy !== 1'b0) begin
            errors++; $display("FAIL oneshot_idle got %b exp 0", io_busy);
        end
    endtask

    task automatic test_collision;
        logic [N-1:0] seen = '0;
        int pulses = 0;
        align(0);
        cfg_write(2'd0, 2'd3, 8'd2);
        cfg_write(2'd1, 2'd3, 8'd2);
        for (int k = 0; k < 16; k++) begin
            checks++;
            if ({io_cfg_ready, io_busy, io_done, io_leds} !== {m_ready, m_busy, m_done, m_leds}) begin
                errors++;
                $display("FAIL coll_done cyc %0d got %b exp %b", k,
                         {io_cfg_ready, io_busy, io_done, io_leds}, {m_ready, m_busy, m_done, m_leds});
            end
            if (io_done !== '0) begin seen = io_done; pulses++; end
            @(negedge clock);
        end
        checks++;
        if (seen !== 3'b011 || pulses != 1) begin
            errors++; $display("FAIL coll_pair got %b x%0d exp 011 x1", seen, pulses);
        end
        cfg_write(2'd0, 2'd2, 8'd1);
        align(TD - 1);
        cfg_write(2'd2, 2'd2, 8'd1);
        for (int k = 0; k < 12; k++) begin
            checks++;
            if ({io_cfg_ready, io_busy, io_done, io_leds} !== {m_ready, m_busy, m_done, m_leds}) begin
                errors++;
                $display("FAIL coll_tick cyc %0d got %b exp %b", k,
                         {io_cfg_ready, io_busy, io_done, io_leds}, {m_ready, m_busy, m_done, m_leds});
            end
            if (k == TD - 1 && io_leds[2] !== 1'b1) begin
                errors++; $display("FAIL coll_hold got %b exp 1", io_leds[2]);
            end
            if (k == TD && io_leds[2] !== 1'b0) begin
                errors++; $display("FAIL coll_toggle got %b exp 0", io_leds[2]);
            end
            @(negedge clock);
        end
        checks += 2;
    endtask

    task automatic test_en_gating;
        logic [N-1:0] snap;
        io_en = 1'b0;
        snap = m_leds;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            checks++;
            if ({io_busy, io_done, io_leds} !== {m_busy, 3'b000, snap}) begin
                errors++;
                $display("FAIL en_frozen cyc %0d got %b exp %b", k,
                         {io_busy, io_done, io_leds}, {m_busy, 3'b000, snap});
            end
        end
        io_en = 1'b1;
        cfg_write(2'd1, 2'd2, 8'd0);
        for (int k = 0; k < 24; k++) begin
            checks++;
            if ({io_cfg_ready, io_busy, io_done, io_leds} !== {m_ready, m_busy, m_done, m_leds}) begin
                errors++;
                $display("FAIL en_resume cyc %0d got %b exp %b", k,
                         {io_cfg_ready, io_busy, io_done, io_leds}, {m_ready, m_busy, m_done, m_leds});
            end
            @(negedge clock);
        end
    endtask

    task automatic test_out_of_range;
        for (int c = 0; c < N; c++) cfg_write(CW'(c), 2'd0, 8'd0);
        cfg_write(2'd3, 2'd1, 8'd5);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if ({io_busy, io_done, io_leds} !== 7'b0 || m_leds !== '0) begin
                errors++;
                $display("FAIL oor cyc %0d got %b exp %b", k, {io_busy, io_done, io_leds}, 7'b0);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_random;
        for (int k = 0; k < 700; k++) begin
            checks++;
            if ({io_cfg_ready, io_busy, io_done, io_leds} !== {m_ready, m_busy, m_done, m_leds}) begin
                errors++;
                $display("FAIL rand cyc %0d got %b exp %b", k,
                         {io_cfg_ready, io_busy, io_done, io_leds}, {m_ready, m_busy, m_done, m_leds});
            end
            if (io_cfg_valid && m_acc) io_cfg_valid = 1'b0;
            if (!io_cfg_valid && $urandom_range(0, 3) == 0) begin
                io_cfg_valid  = 1'b1;
                io_cfg_chan   = CW'($urandom_range(0, 3));
                io_cfg_mode   = 2'($urandom_range(0, 3));
                io_cfg_period = PW'($urandom_range(0, 3));
            end
            io_en = ($urandom_range(0, 9) != 0);
            @(negedge clock);
        end
        io_cfg_valid = 1'b0;
        io_en = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_reset_mid;
        cfg_write(2'd1, 2'd2, 8'd3);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({io_cfg_ready, io_busy, io_done, io_leds} !== 8'b0) begin
            errors++;
            $display("FAIL reset_async got %b exp %b",
                     {io_cfg_ready, io_busy, io_done, io_leds}, 8'b0);
        end
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            checks++;
            if ({io_cfg_ready, io_busy, io_done, io_leds} !== {m_ready, m_busy, m_done, m_leds}) begin
                errors++;
                $display("FAIL reset_after cyc %0d got %b exp %b", k,
                         {io_cfg_ready, io_busy, io_done, io_leds}, {m_ready, m_busy, m_done, m_leds});
            end
        end
    endtask

    initial begin
        test_reset;
        test_blink;
        test_oneshot;
        test_collision;
        test_en_gating;
        test_out_of_range;
        test_random;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
